// File: rtl/airlock_sequencer_pkg.sv
// Shared types for the bay airlock sequencer: state encoding, actuator bundle
// and the Moore output decode.
package airlock_sequencer_pkg;

    localparam int PUMP_CYCLES_DEF = 8;
    localparam int DOOR_CYCLES_DEF = 2;
    localparam int TIMEOUT_DEF     = 32;

    typedef enum logic [3:0] {
        ST_RST_HOLD   = 4'd0,
        ST_RECOVER    = 4'd1,
        ST_IDLE       = 4'd2,
        ST_EVAC_ARR   = 4'd3,
        ST_EVAC_DEP   = 4'd4,
        ST_OPEN_ARR   = 4'd5,
        ST_OPEN_DEP   = 4'd6,
        ST_CLOSE_ARR  = 4'd7,
        ST_CLOSE_DEP  = 4'd8,
        ST_PRESS_ARR  = 4'd9,
        ST_PRESS_DEP  = 4'd10,
        ST_INNER_OPEN = 4'd11,
        ST_ABORT      = 4'd12
    } state_e;

    typedef struct packed {
        logic outer_door;
        logic inner_door;
        logic pump_out;
        logic pump_in;
        logic pressurized;
        logic busy;
        logic fault;
    } act_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // RST_HOLD decodes to all-zero, so busy is cleared there as well as in IDLE.
    function automatic act_t decode(input state_e s);
        act_t a;
        a = '0;
        a.busy = (s != ST_IDLE) && (s != ST_RST_HOLD);
        case (s)
            ST_RECOVER, ST_PRESS_ARR, ST_PRESS_DEP: a.pump_in    = 1'b1;
            ST_EVAC_ARR, ST_EVAC_DEP:               a.pump_out   = 1'b1;
            ST_OPEN_ARR, ST_OPEN_DEP:               a.outer_door = 1'b1;
            ST_INNER_OPEN:                          a.inner_door = 1'b1;
            ST_IDLE:                                a.pressurized = 1'b1;
            ST_ABORT:                               a.fault      = 1'b1;
            default:                                ;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/airlock_sequencer_dwell_timer.sv
// Down-counting dwell timer: load sets the count, done flags a count of zero.
module dwell_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] loadValue,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= loadValue;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = (count == '0);

endmodule

// File: rtl/airlock_sequencer.sv
// Moore FSM sequencing the bay airlock doors and pumps around ship presence,
// with timed dwell phases so vacuum and station side are never joined.
module airlock_sequencer
    import airlock_sequencer_pkg::*;
#(
    parameter int PUMP_CYCLES = PUMP_CYCLES_DEF,
    parameter int DOOR_CYCLES = DOOR_CYCLES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic arriving,
    input  logic departing,
    input  logic shipDocked,
    output logic outerDoor,
    output logic innerDoor,
    output logic pumpOut,
    output logic pumpIn,
    output logic pressurized,
    output logic busy,
    output logic fault
);

    localparam int TW = $clog2(max3(PUMP_CYCLES, DOOR_CYCLES, TIMEOUT)) + 1;

    state_e        state_q;
    state_e        state_nx;
    act_t          act_q;
    logic          tmr_done;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_RST_HOLD:   state_nx = ST_RECOVER;
            ST_RECOVER:    if (tmr_done) state_nx = ST_IDLE;
            ST_IDLE: begin
                if (departing && shipDocked)
                    state_nx = ST_EVAC_DEP;
                else if (arriving && !shipDocked)
                    state_nx = ST_EVAC_ARR;
            end
            ST_EVAC_ARR:   if (tmr_done) state_nx = ST_OPEN_ARR;
            ST_EVAC_DEP:   if (tmr_done) state_nx = ST_OPEN_DEP;
            // Normal exit is tested before expiry so it wins on a shared edge.
            ST_OPEN_ARR: begin
                if (shipDocked)     state_nx = ST_CLOSE_ARR;
                else if (tmr_done)  state_nx = ST_ABORT;
            end
            ST_OPEN_DEP: begin
                if (!shipDocked)    state_nx = ST_CLOSE_DEP;
                else if (tmr_done)  state_nx = ST_ABORT;
            end
            ST_CLOSE_ARR:  if (tmr_done) state_nx = ST_PRESS_ARR;
            ST_CLOSE_DEP:  if (tmr_done) state_nx = ST_PRESS_DEP;
            ST_PRESS_ARR:  if (tmr_done) state_nx = ST_INNER_OPEN;
            ST_PRESS_DEP:  if (tmr_done) state_nx = ST_IDLE;
            ST_INNER_OPEN: if (tmr_done) state_nx = ST_IDLE;
            ST_ABORT:      state_nx = ST_CLOSE_DEP;
            default:       state_nx = ST_RST_HOLD;
        endcase
    end

    // The timer is reloaded with N-1 on the same edge the new state is entered.
    always_comb begin
        tmr_val = '0;
        case (state_nx)
            ST_RECOVER, ST_EVAC_ARR, ST_EVAC_DEP, ST_PRESS_ARR, ST_PRESS_DEP:
                tmr_val = TW'(PUMP_CYCLES - 1);
            ST_CLOSE_ARR, ST_CLOSE_DEP, ST_INNER_OPEN:
                tmr_val = TW'(DOOR_CYCLES - 1);
            ST_OPEN_ARR, ST_OPEN_DEP:
                tmr_val = TW'(TIMEOUT - 1);
            default:
                tmr_val = '0;
        endcase
    end

    assign tmr_load = (state_nx != state_q);

    dwell_timer #(
        .W (TW)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .load      (tmr_load),
        .loadValue (tmr_val),
        .done      (tmr_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RST_HOLD;
            act_q   <= '0;
        end else begin
            state_q <= state_nx;
            act_q   <= decode(state_nx);
        end
    end

    assign outerDoor   = act_q.outer_door;
    assign innerDoor   = act_q.inner_door;
    assign pumpOut     = act_q.pump_out;
    assign pumpIn      = act_q.pump_in;
    assign pressurized = act_q.pressurized;
    assign busy        = act_q.busy;
    assign fault       = act_q.fault;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed scoreboard bench for airlock_sequencer with PUMP=4, DOOR=2, TIMEOUT=10.
module tb_airlock_sequencer;

    logic clock = 1'b0;
    logic reset;
    logic arriving   = 1'b0;
    logic departing  = 1'b0;
    logic shipDocked = 1'b0;
    logic outerDoor, innerDoor, pumpOut, pumpIn, pressurized, busy, fault;

    // {outerDoor, innerDoor, pumpOut, pumpIn, pressurized, busy, fault}
    localparam logic [6:0] V_ZERO   = 7'b0000000;
    localparam logic [6:0] V_PUMPIN = 7'b0001010;
    localparam logic [6:0] V_IDLE   = 7'b0000100;
    localparam logic [6:0] V_EVAC   = 7'b0010010;
    localparam logic [6:0] V_OPEN   = 7'b1000010;
    localparam logic [6:0] V_CLOSED = 7'b0000010;
    localparam logic [6:0] V_INNER  = 7'b0100010;
    localparam logic [6:0] V_ABORT  = 7'b0000011;

    typedef struct {
        logic [6:0] v;
        string      tag;
    } exp_t;

    exp_t  sb[$];
    string phase = "reset";
    int    n_vec = 0;
    int    n_err = 0;

    airlock_sequencer #(
        .PUMP_CYCLES (4),
        .DOOR_CYCLES (2),
        .TIMEOUT     (10)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .arriving    (arriving),
        .departing   (departing),
        .shipDocked  (shipDocked),
        .outerDoor   (outerDoor),
        .innerDoor   (innerDoor),
        .pumpOut     (pumpOut),
        .pumpIn      (pumpIn),
        .pressurized (pressurized),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] outs();
        return {outerDoor, innerDoor, pumpOut, pumpIn, pressurized, busy, fault};
    endfunction

    // Monitor: one expected vector per cycle, sampled on the falling edge.
    always @(negedge clock) begin
        exp_t e;
        logic [6:0] got;
        got = outs();
        n_vec++;
        if (outerDoor && innerDoor) begin
            n_err++;
            $display("FAIL door_interlock t=%0t got outer=%b inner=%b required not both", $time, outerDoor, innerDoor);
        end
        n_vec++;
        if (pumpIn && pumpOut) begin
            n_err++;
            $display("FAIL pump_interlock t=%0t got in=%b out=%b required not both", $time, pumpIn, pumpOut);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if (got !== e.v) begin
                n_err++;
                $display("FAIL %s t=%0t got %b required %b", e.tag, $time, got, e.v);
            end
        end
    end

    task automatic cyc(input logic [6:0] v);
        exp_t e;
        @(posedge clock);
        #1;
        e.v = v;
        e.tag = phase;
        sb.push_back(e);
    endtask

    task automatic run(input int n, input logic [6:0] v);
        for (int i = 0; i < n; i++) cyc(v);
    endtask

    task automatic direct_check(input string tag, input logic [6:0] v);
        n_vec++;
        if (outs() !== v) begin
            n_err++;
            $display("FAIL %s t=%0t got %b required %b", tag, $time, outs(), v);
        end
    endtask

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        #2 direct_check("reset_async", V_ZERO);

        phase = "reset_hold";
        run(2, V_ZERO);
        reset = 1'b1;
        phase = "recover";
        run(4, V_PUMPIN);
        phase = "recover_idle";
        cyc(V_IDLE);

        // Arrival, with a stray departure request during evacuation.
        arriving = 1'b1;
        phase = "arr_evac";
        cyc(V_EVAC);
        arriving = 1'b0;
        departing = 1'b1;
        run(3, V_EVAC);
        departing = 1'b0;
        phase = "arr_open";
        run(3, V_OPEN);
        shipDocked = 1'b1;
        phase = "arr_close";
        run(2, V_CLOSED);
        phase = "arr_press";
        run(4, V_PUMPIN);
        phase = "arr_inner";
        run(2, V_INNER);
        phase = "arr_idle";
        cyc(V_IDLE);

        // Arrival with ship already docked is ignored.
        arriving = 1'b1;
        phase = "illegal_arr";
        run(20, V_IDLE);

        // Both requests with ship docked: departure wins.
        departing = 1'b1;
        phase = "dep_evac";
        cyc(V_EVAC);
        arriving = 1'b0;
        departing = 1'b0;
        run(3, V_EVAC);
        phase = "dep_open";
        run(2, V_OPEN);
        shipDocked = 1'b0;
        phase = "dep_close";
        run(2, V_CLOSED);
        phase = "dep_press";
        run(4, V_PUMPIN);
        phase = "dep_idle";
        cyc(V_IDLE);

        // Timeout abort; departing held so IDLE re-entry relaunches at once.
        shipDocked = 1'b1;
        departing = 1'b1;
        phase = "to_evac";
        run(4, V_EVAC);
        phase = "to_open";
        run(10, V_OPEN);
        phase = "to_fault";
        cyc(V_ABORT);
        phase = "to_close";
        run(2, V_CLOSED);
        phase = "to_press";
        run(4, V_PUMPIN);
        phase = "to_idle";
        cyc(V_IDLE);
        phase = "held_request";
        cyc(V_EVAC);
        departing = 1'b0;
        run(3, V_EVAC);

        // Exit condition on the same edge as expiry: normal close wins.
        phase = "tie_open";
        run(10, V_OPEN);
        shipDocked = 1'b0;
        phase = "tie_close";
        run(2, V_CLOSED);
        phase = "tie_press";
        run(4, V_PUMPIN);
        phase = "tie_idle";
        cyc(V_IDLE);

        // Reset in the middle of OPEN_ARR.
        arriving = 1'b1;
        phase = "mid_evac";
        cyc(V_EVAC);
        arriving = 1'b0;
        run(3, V_EVAC);
        phase = "mid_open";
        run(2, V_OPEN);
        @(negedge clock);
        #1 reset = 1'b0;
        #1 direct_check("mid_reset_async", V_ZERO);
        phase = "mid_hold";
        run(2, V_ZERO);
        reset = 1'b1;
        phase = "mid_recover";
        run(4, V_PUMPIN);
        phase = "mid_idle";
        cyc(V_IDLE);
        run(2, V_IDLE);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
